fetch_pc_unit: RTL and testbench

//  IF-stage PC generator and instruction-fetch sequencer; sits directly upstream of branch_predictor.

---
 rtl/fetch_pc_unit.sv | 136 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator and instruction-fetch sequencer: predictor lookup, req/ack imem fetch,
// and an IF/ID output register with a one-entry pending slot for stalls.
module fetch_pc_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] bp_query_pc,
  input  logic                 bp_predict,
  input  logic [WORD_SIZE-1:0] bp_target,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [WORD_SIZE-1:0] imem_data,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc_plus_1,
  output logic                 out_predict,
  output logic [WORD_SIZE-1:0] out_pred_pc
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  state_t               state_reg, state_next;
  logic [WORD_SIZE-1:0] pc_reg, drain_addr_reg;
  logic [WORD_SIZE-1:0] pend_instr_reg, pend_pc_plus_1_reg, pend_pred_pc_reg;
  logic                 pend_predict_reg;
  logic                 out_valid_reg, out_predict_reg;
  logic [WORD_SIZE-1:0] out_instr_reg, out_pc_plus_1_reg, out_pred_pc_reg;

  logic [WORD_SIZE-1:0] pc_plus_1, next_pc;
  logic                 slot_free;

  assign pc_plus_1   = pc_reg + ONE;
  assign next_pc     = bp_predict ? bp_target : pc_plus_1;
  assign slot_free   = !out_valid_reg || !stall;
  assign bp_query_pc = pc_plus_1;

  assign out_valid     = out_valid_reg;
  assign out_instr     = out_instr_reg;
  assign out_pc_plus_1 = out_pc_plus_1_reg;
  assign out_predict   = out_predict_reg;
  assign out_pred_pc   = out_pred_pc_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (redirect_valid)               state_next = imem_ack ? S_FETCH : S_DRAIN;
        else if (imem_ack && !slot_free)  state_next = S_HOLD;
      end
      S_HOLD:  if (redirect_valid || !stall) state_next = S_FETCH;
      S_DRAIN: if (imem_ack)                 state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  // The drain state re-presents the abandoned address so imem_addr never moves mid-request.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state_reg)
      S_FETCH: imem_req = 1'b1;
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_reg;
      end
      default: imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg             <= RESET_PC;
      drain_addr_reg     <= '0;
      pend_instr_reg     <= '0;
      pend_pc_plus_1_reg <= '0;
      pend_predict_reg   <= 1'b0;
      pend_pred_pc_reg   <= '0;
      out_valid_reg      <= 1'b0;
      out_instr_reg      <= '0;
      out_pc_plus_1_reg  <= '0;
      out_predict_reg    <= 1'b0;
      out_pred_pc_reg    <= '0;
    end else begin
      if (out_valid_reg && !stall) out_valid_reg <= 1'b0;
      if (redirect_valid) begin
        pc_reg        <= redirect_pc;
        out_valid_reg <= 1'b0;
        if (state_reg == S_FETCH && !imem_ack) drain_addr_reg <= pc_reg;
      end else begin
        case (state_reg)
          S_FETCH: begin
            if (imem_ack) begin
              pc_reg <= next_pc;
              if (slot_free) begin
                out_valid_reg     <= 1'b1;
                out_instr_reg     <= imem_data;
                out_pc_plus_1_reg <= pc_plus_1;
                out_predict_reg   <= bp_predict;
                out_pred_pc_reg   <= next_pc;
              end else begin
                pend_instr_reg     <= imem_data;
                pend_pc_plus_1_reg <= pc_plus_1;
                pend_predict_reg   <= bp_predict;
                pend_pred_pc_reg   <= next_pc;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              out_valid_reg     <= 1'b1;
              out_instr_reg     <= pend_instr_reg;
              out_pc_plus_1_reg <= pend_pc_plus_1_reg;
              out_predict_reg   <= pend_predict_reg;
              out_pred_pc_reg   <= pend_pred_pc_reg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, streaming fetch, prediction, stall/hold,
// redirect during a slow fetch, redirect under stall, PC wrap and mid-request reset.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset_n, stall, redirect_valid, bp_predict, imem_ack;
  logic [15:0] redirect_pc, bp_target, imem_data;
  logic [15:0] bp_query_pc, imem_addr, out_instr, out_pc_plus_1, out_pred_pc;
  logic        imem_req, out_valid, out_predict;
  int          vectors = 0;
  int          miscompares = 0;

  fetch_pc_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_query_pc(bp_query_pc), .bp_predict(bp_predict), .bp_target(bp_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus_1(out_pc_plus_1),
    .out_predict(out_predict), .out_pred_pc(out_pred_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v)
      $display("vec %0d %s observed=%h expected=%h ok", vectors, tag, obs, exp_v);
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bp_predict = 1'b0; bp_target = '0; imem_ack = 1'b0; imem_data = '0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    chk("rst_req", {15'b0, imem_req}, 16'h0001);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_query", bp_query_pc, 16'h0001);
    chk("rst_instr", out_instr, 16'h0000);

    // zero-latency stream
    imem_ack = 1'b1; imem_data = 16'h6001; tick();
    chk("s1_valid", {15'b0, out_valid}, 16'h0001);
    chk("s1_instr", out_instr, 16'h6001);
    chk("s1_pcp1", out_pc_plus_1, 16'h0001);
    chk("s1_addr", imem_addr, 16'h0001);
    imem_data = 16'h6002; tick();
    chk("s2_pcp1", out_pc_plus_1, 16'h0002);
    chk("s2_addr", imem_addr, 16'h0002);
    imem_data = 16'h6003; tick();
    chk("s3_instr", out_instr, 16'h6003);
    chk("s3_pcp1", out_pc_plus_1, 16'h0003);
    chk("s3_addr", imem_addr, 16'h0003);
    imem_data = 16'h6004; tick();
    imem_data = 16'h6005; tick();
    chk("s5_addr", imem_addr, 16'h0005);
    chk("s5_query", bp_query_pc, 16'h0006);

    // predicted taken at pc 5
    bp_predict = 1'b1; bp_target = 16'h0020; imem_data = 16'h6006; tick();
    chk("bp_predict", {15'b0, out_predict}, 16'h0001);
    chk("bp_pred_pc", out_pred_pc, 16'h0020);
    chk("bp_pcp1", out_pc_plus_1, 16'h0006);
    chk("bp_addr", imem_addr, 16'h0020);
    bp_predict = 1'b0;

    // stall with an ack -> hold
    stall = 1'b1; imem_data = 16'hABCD; tick();
    imem_ack = 1'b0;
    chk("hold_req", {15'b0, imem_req}, 16'h0000);
    chk("hold_instr", out_instr, 16'h6006);
    chk("hold_valid", {15'b0, out_valid}, 16'h0001);
    tick();
    chk("hold2_instr", out_instr, 16'h6006);
    stall = 1'b0; tick();
    chk("rel_instr", out_instr, 16'hABCD);
    chk("rel_valid", {15'b0, out_valid}, 16'h0001);
    chk("rel_pcp1", out_pc_plus_1, 16'h0021);
    chk("rel_req", {15'b0, imem_req}, 16'h0001);
    chk("rel_addr", imem_addr, 16'h0021);

    // jump to 0x10, then redirect during a slow fetch
    imem_ack = 1'b1; imem_data = 16'h7000; bp_predict = 1'b1; bp_target = 16'h0010; tick();
    imem_ack = 1'b0; bp_predict = 1'b0;
    chk("j_addr", imem_addr, 16'h0010);
    chk("j_pred_pc", out_pred_pc, 16'h0010);
    tick();
    chk("w1_valid", {15'b0, out_valid}, 16'h0000);
    chk("w1_addr", imem_addr, 16'h0010);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; tick();
    redirect_valid = 1'b0;
    chk("rd_req", {15'b0, imem_req}, 16'h0001);
    chk("rd_addr", imem_addr, 16'h0010);
    tick();
    chk("rd2_addr", imem_addr, 16'h0010);
    imem_ack = 1'b1; imem_data = 16'hDEAD; tick();
    imem_ack = 1'b0;
    chk("rd_drop_valid", {15'b0, out_valid}, 16'h0000);
    chk("rd_new_addr", imem_addr, 16'h0100);

    // redirect while stalled still flushes
    imem_ack = 1'b1; imem_data = 16'h1111; tick();
    chk("f_instr", out_instr, 16'h1111);
    imem_ack = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFF; tick();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("fs_valid", {15'b0, out_valid}, 16'h0000);
    chk("fs_addr", imem_addr, 16'h0101);
    imem_ack = 1'b1; imem_data = 16'h3333; tick();
    chk("fs_drop_valid", {15'b0, out_valid}, 16'h0000);
    chk("wrap_addr", imem_addr, 16'hFFFF);
    chk("wrap_query", bp_query_pc, 16'h0000);

    // wrap at 0xFFFF
    imem_data = 16'h2222; tick();
    chk("wrap_instr", out_instr, 16'h2222);
    chk("wrap_pcp1", out_pc_plus_1, 16'h0000);
    chk("wrap_pred_pc", out_pred_pc, 16'h0000);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // reset mid-request
    imem_ack = 1'b0; tick(); tick();
    reset_n = 1'b0; imem_ack = 1'b1; imem_data = 16'h4444; tick();
    chk("mr_valid", {15'b0, out_valid}, 16'h0000);
    chk("mr_instr", out_instr, 16'h0000);
    chk("mr_addr", imem_addr, 16'h0000);
    reset_n = 1'b1; imem_ack = 1'b0;
    tick();
    chk("mr_req", {15'b0, imem_req}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
